// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access FIFO and its issue stage:
// default widths, issue FSM states and the wrap-safe timestamp compare.
package mem_access_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH
  } issue_state_e;

  // Modular distance from a timestamp to now; small positive values mean "past due".
  function automatic logic [TIME_W-1:0] time_slack(input logic [TIME_W-1:0] now_t,
                                                   input logic [TIME_W-1:0] at_t);
    return now_t - at_t;
  endfunction

  // Due when now is at or after at_t, valid while the two are within half the time range.
  function automatic logic time_due(input logic [TIME_W-1:0] now_t,
                                    input logic [TIME_W-1:0] at_t);
    logic [TIME_W-1:0] d;
    d = time_slack(now_t, at_t);
    return ~d[TIME_W-1];
  endfunction

endpackage

// File: rtl/lat_shift.sv
// Fixed-depth valid+tag delay line tracking reads in flight through the RAM.
// clear drops every valid bit in one edge; tags are don't-care without a valid.
module lat_shift #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_tag,
  output logic             busy_next
);

  localparam logic [DEPTH-1:0] LAST_STAGE = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] tag_q [DEPTH];

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  // Something is still in flight after this edge: a new read or any stage short of the exit.
  assign busy_next = in_valid | (|(valid_q & ~LAST_STAGE));

  // NOTE: non-blocking assignments let every stage read its neighbour's old value on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      // NOTE: the tag stages are a small register pipeline, so clearing them on reset is cheap and keeps outputs defined.
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid & ~clear;
      tag_q[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~clear;
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

endmodule

// File: rtl/mem_access_issue.sv
// Issue stage behind MemAccessFIFO: pops the head once its out-time is reached,
// reads the RAM and returns the data tagged with the entry's residence time.
module mem_access_issue #(
  parameter int ADDR_W  = mem_access_pkg::ADDR_W,
  parameter int DATA_W  = mem_access_pkg::DATA_W,
  parameter int TIME_W  = mem_access_pkg::TIME_W,
  parameter int RAM_LAT = 2,
  parameter int LATE_TH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] count,
  input  logic              head_valid,
  input  logic [ADDR_W-1:0] RAM_Addr_i,
  input  logic [TIME_W-1:0] HeadOutTime,
  input  logic [TIME_W-1:0] HeadInTime,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              o,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic [TIME_W-1:0] resid_o,
  output logic              late_o,
  output logic [7:0]        late_cnt
);
  import mem_access_pkg::*;

  issue_state_e      state_q, state_d;
  logic [TIME_W-1:0] slack, resid, ret_tag;
  logic              due, issue, in_flush, clear, take, ret_valid, busy_next;

  assign in_flush = (state_q == ST_FLUSH);
  assign slack    = time_slack(count, HeadOutTime);
  // head_valid gates first so a garbage timestamp on an empty FIFO never pops.
  assign due      = head_valid & time_due(count, HeadOutTime);
  assign issue    = due & ~stall_i & ~flush_i & ~in_flush & ~reset;
  assign resid    = count - HeadInTime;

  assign o        = issue;
  assign ram_en   = issue;
  assign ram_addr = issue ? RAM_Addr_i : '0;
  assign late_o   = issue & (slack > TIME_W'(LATE_TH));

  assign clear    = flush_i | in_flush;
  assign take     = ret_valid & ~clear;

  lat_shift #(
    .DEPTH (RAM_LAT),
    .WIDTH (TIME_W)
  ) u_lat_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (issue),
    .in_tag    (resid),
    .out_valid (ret_valid),
    .out_tag   (ret_tag),
    .busy_next (busy_next)
  );

  always_comb begin
    // NOTE: assigning the default first covers every path, so no latch is inferred.
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = busy_next ? ST_BUSY : ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      resid_o      <= '0;
      late_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      data_valid_o <= take;
      if (take) begin
        data_o  <= ram_rdata;
        resid_o <= ret_tag;
      end
      if (late_o && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
    end
  end

endmodule
